rgb2ycbcr_coef_ctrl: RTL and testbench

Coefficient configuration controller for the `rgb_2_ycbcr` colour-space converter. It holds a shadow and an active copy of the 3x3 matrix and the three offsets. Software or presets write the shadow copy. A commit request copies shadow to active only at the next frame boundary (rising edge of `vs_i`), so the converter never sees a coefficient change mid-frame. The active outputs drive the converter's `CI_Axx` / `CI_Cx` inputs directly.

---
 rtl/rgb2ycbcr_coef_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_rgb2ycbcr_coef_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2ycbcr_coef_ctrl.sv
// Shadow/active coefficient bank for rgb_2_ycbcr; a commit copies shadow to active only at a vs rising edge or timeout.
// Latency: shadow writes land on the handshake edge, active updates 1 cycle after vs rises; wr_ready_o drops while a commit is pending or a preset loads.
module rgb2ycbcr_coef_ctrl #(
    parameter int COEF_WIDTH     = 16,
    parameter int PIXEL_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 4194304
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_valid_i,
    output logic                         wr_ready_o,
    input  logic [3:0]                   wr_addr_i,
    input  logic signed [COEF_WIDTH-1:0] wr_data_i,
    input  logic                         preset_load_i,
    input  logic [1:0]                   preset_sel_i,
    input  logic                         commit_i,
    input  logic                         vs_i,
    output logic signed [COEF_WIDTH-1:0] a00_o,
    output logic signed [COEF_WIDTH-1:0] a01_o,
    output logic signed [COEF_WIDTH-1:0] a02_o,
    output logic signed [COEF_WIDTH-1:0] a10_o,
    output logic signed [COEF_WIDTH-1:0] a11_o,
    output logic signed [COEF_WIDTH-1:0] a12_o,
    output logic signed [COEF_WIDTH-1:0] a20_o,
    output logic signed [COEF_WIDTH-1:0] a21_o,
    output logic signed [COEF_WIDTH-1:0] a22_o,
    output logic signed [COEF_WIDTH-1:0] c0_o,
    output logic signed [COEF_WIDTH-1:0] c1_o,
    output logic signed [COEF_WIDTH-1:0] c2_o,
    output logic                         pending_o,
    output logic                         apply_o,
    output logic                         forced_o,
    output logic                         err_o
);

    typedef logic signed [COEF_WIDTH-1:0] coef_t;
    typedef coef_t [11:0] coef_bank_t;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam coef_t OFS_HALF = coef_t'(2 ** (PIXEL_WIDTH - 1));

    // Bank index: 0..8 = A00..A22 row-major, 9..11 = C0..C2.
    function automatic coef_bank_t preset_bank(input logic [1:0] sel);
        coef_bank_t b;
        b = '0;
        case (sel)
            2'd0: begin
                b[0]  = coef_t'(306);  b[1] = coef_t'(601);  b[2] = coef_t'(117);
                b[3]  = coef_t'(-173); b[4] = coef_t'(-339); b[5] = coef_t'(512);
                b[6]  = coef_t'(512);  b[7] = coef_t'(-429); b[8] = coef_t'(-83);
                b[10] = OFS_HALF;      b[11] = OFS_HALF;
            end
            2'd1: begin
                b[0]  = coef_t'(218);  b[1] = coef_t'(732);  b[2] = coef_t'(74);
                b[3]  = coef_t'(-117); b[4] = coef_t'(-395); b[5] = coef_t'(512);
                b[6]  = coef_t'(512);  b[7] = coef_t'(-465); b[8] = coef_t'(-47);
                b[10] = OFS_HALF;      b[11] = OFS_HALF;
            end
            default: begin
                b[0] = coef_t'(1024);
                b[4] = coef_t'(1024);
                b[8] = coef_t'(1024);
            end
        endcase
        return b;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_vs_q;
    logic [CNT_W-1:0] r_cnt;
    coef_bank_t       r_shadow;
    coef_bank_t       r_active;
    logic             r_apply;
    logic             r_forced;
    logic             r_err;

    logic w_vs_rise;
    logic w_timeout;
    logic w_apply;
    logic w_apply_forced;
    logic w_wr_acc;
    logic w_preset_ok;

    assign w_vs_rise   = vs_i & ~r_vs_q;
    assign w_timeout   = (TIMEOUT_CYCLES > 0) && (r_cnt == CNT_LAST);
    assign wr_ready_o  = (r_state == ST_IDLE) && !preset_load_i;
    assign w_wr_acc    = wr_valid_i && wr_ready_o && (wr_addr_i < 4'd12);
    assign w_preset_ok = preset_load_i && (r_state == ST_IDLE) && (preset_sel_i != 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An edge wins over a same-cycle timeout, so forced only reflects a pure timeout.
    always_comb begin
        w_state_nxt    = r_state;
        w_apply        = 1'b0;
        w_apply_forced = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (commit_i) begin
                    w_state_nxt = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (w_vs_rise || w_timeout) begin
                    w_apply        = 1'b1;
                    w_apply_forced = !w_vs_rise;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_q <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_vs_q <= vs_i;
            if (r_state == ST_PENDING) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= preset_bank(2'd0);
            r_active <= preset_bank(2'd0);
        end else begin
            if (w_preset_ok) begin
                r_shadow <= preset_bank(preset_sel_i);
            end else if (w_wr_acc) begin
                r_shadow[wr_addr_i] <= wr_data_i;
            end
            if (w_apply) begin
                r_active <= r_shadow;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_apply  <= 1'b0;
            r_forced <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_apply <= w_apply;
            r_err   <= preset_load_i && (preset_sel_i == 2'd3);
            if (w_apply) begin
                r_forced <= w_apply_forced;
            end
        end
    end

    assign a00_o     = r_active[0];
    assign a01_o     = r_active[1];
    assign a02_o     = r_active[2];
    assign a10_o     = r_active[3];
    assign a11_o     = r_active[4];
    assign a12_o     = r_active[5];
    assign a20_o     = r_active[6];
    assign a21_o     = r_active[7];
    assign a22_o     = r_active[8];
    assign c0_o      = r_active[9];
    assign c1_o      = r_active[10];
    assign c2_o      = r_active[11];
    assign pending_o = (r_state == ST_PENDING);
    assign apply_o   = r_apply;
    assign forced_o  = r_forced;
    assign err_o     = r_err;

endmodule

// File: tb/tb_rgb2ycbcr_coef_ctrl.sv
// Bench for rgb2ycbcr_coef_ctrl: three instances (no practical timeout, 16, 1) share one stimulus stream
// and are compared every cycle against a frame-level model of shadow/active banks.
module tb_rgb2ycbcr_coef_ctrl;

    localparam int NI   = 3;
    localparam int HALF = (1 << 8) / 2;

    logic              clk         = 1'b0;
    logic              rst_n       = 1'b0;
    logic              wr_valid    = 1'b0;
    logic [3:0]        wr_addr     = 4'd0;
    logic signed [15:0] wr_data    = 16'sd0;
    logic              preset_load = 1'b0;
    logic [1:0]        preset_sel  = 2'd0;
    logic              commit      = 1'b0;
    logic              vs          = 1'b0;

    logic signed [15:0] act [NI][12];
    logic [NI-1:0]      wr_ready;
    logic [NI-1:0]      pending;
    logic [NI-1:0]      apply;
    logic [NI-1:0]      forced;
    logic [NI-1:0]      err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        rgb2ycbcr_coef_ctrl #(
            .COEF_WIDTH    (16),
            .PIXEL_WIDTH   (8),
            .TIMEOUT_CYCLES((g == 0) ? 4194304 : ((g == 1) ? 16 : 1))
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .wr_valid_i   (wr_valid),
            .wr_ready_o   (wr_ready[g]),
            .wr_addr_i    (wr_addr),
            .wr_data_i    (wr_data),
            .preset_load_i(preset_load),
            .preset_sel_i (preset_sel),
            .commit_i     (commit),
            .vs_i         (vs),
            .a00_o        (act[g][0]),
            .a01_o        (act[g][1]),
            .a02_o        (act[g][2]),
            .a10_o        (act[g][3]),
            .a11_o        (act[g][4]),
            .a12_o        (act[g][5]),
            .a20_o        (act[g][6]),
            .a21_o        (act[g][7]),
            .a22_o        (act[g][8]),
            .c0_o         (act[g][9]),
            .c1_o         (act[g][10]),
            .c2_o         (act[g][11]),
            .pending_o    (pending[g]),
            .apply_o      (apply[g]),
            .forced_o     (forced[g]),
            .err_o        (err[g])
        );
    end

    // Reference model: per instance, a shadow and active bank plus a "commit waiting" flag.
    int tmo [NI] = '{4194304, 16, 1};
    int m_sh [NI][12];
    int m_ac [NI][12];
    int m_wait [NI];
    bit m_pend [NI];
    bit m_forced [NI];
    bit m_apply [NI];
    bit m_err [NI];
    bit m_vs_prev [NI];

    function automatic int preset_val(input int sel, input int i);
        int bt601 [12] = '{306, 601, 117, -173, -339, 512, 512, -429, -83, 0, HALF, HALF};
        int bt709 [12] = '{218, 732, 74, -117, -395, 512, 512, -465, -47, 0, HALF, HALF};
        if (sel == 0) return bt601[i];
        if (sel == 1) return bt709[i];
        return (i == 0 || i == 4 || i == 8) ? 1024 : 0;
    endfunction

    task automatic check_val(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int k);
        for (int i = 0; i < 12; i++) begin
            m_sh[k][i] = preset_val(0, i);
            m_ac[k][i] = preset_val(0, i);
        end
        m_pend[k]    = 1'b0;
        m_wait[k]    = 0;
        m_forced[k]  = 1'b0;
        m_apply[k]   = 1'b0;
        m_err[k]     = 1'b0;
        m_vs_prev[k] = 1'b0;
    endtask

    task automatic model_clock(input int k);
        bit rise;
        rise       = vs && !m_vs_prev[k];
        m_apply[k] = 1'b0;
        m_err[k]   = preset_load && (preset_sel == 2'd3);
        if (!m_pend[k]) begin
            if (preset_load) begin
                if (preset_sel != 2'd3)
                    for (int i = 0; i < 12; i++) m_sh[k][i] = preset_val(int'(preset_sel), i);
            end else if (wr_valid && wr_addr < 4'd12) begin
                m_sh[k][wr_addr] = int'(wr_data);
            end
            if (commit) begin
                m_pend[k] = 1'b1;
                m_wait[k] = 0;
            end
        end else begin
            m_wait[k]++;
            if (rise || (tmo[k] > 0 && m_wait[k] == tmo[k])) begin
                for (int i = 0; i < 12; i++) m_ac[k][i] = m_sh[k][i];
                m_apply[k]  = 1'b1;
                m_forced[k] = !rise;
                m_pend[k]   = 1'b0;
            end
        end
        m_vs_prev[k] = vs;
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 12; i++)
                check_val($sformatf("u%0d_coef%0d", k, i), act[k][i], m_ac[k][i]);
            check_val($sformatf("u%0d_pending", k), pending[k], m_pend[k]);
            check_val($sformatf("u%0d_apply", k), apply[k], m_apply[k]);
            check_val($sformatf("u%0d_forced", k), forced[k], m_forced[k]);
            check_val($sformatf("u%0d_err", k), err[k], m_err[k]);
            check_val($sformatf("u%0d_wr_ready", k), wr_ready[k], !m_pend[k] && !preset_load);
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) model_reset(k);
            else        model_clock(k);
        end
        #1;
        check_all();
    endtask

    initial begin
        for (int k = 0; k < NI; k++) model_reset(k);

        // Reset and release
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check_val("rst_a00", act[0][0], 306);
        check_val("rst_a21", act[0][7], -429);
        check_val("rst_c1", act[0][10], 128);
        check_val("rst_pending", pending[0], 0);
        check_val("rst_ready", wr_ready[0], 1);

        // Write A00 = 400, commit, vs edge 50 cycles later
        wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 16'sd400;
        step();
        wr_valid = 1'b0; commit = 1'b1;
        step();
        commit = 1'b0;
        repeat (50) step();
        check_val("hold_a00", act[0][0], 306);
        check_val("hold_pending", pending[0], 1);
        vs = 1'b1;
        step();
        check_val("edge_a00", act[0][0], 400);
        check_val("edge_apply", apply[0], 1);
        step();
        check_val("edge_apply_once", apply[0], 0);

        // BT.709 preset + commit, then a second commit and writes while locked
        vs = 1'b0;
        step();
        preset_load = 1'b1; preset_sel = 2'd1; commit = 1'b1;
        step();
        preset_load = 1'b0; commit = 1'b0;
        repeat (3) step();
        commit = 1'b1; wr_valid = 1'b1; wr_addr = 4'd1; wr_data = 16'sd5;
        step();
        commit = 1'b0;
        check_val("locked_ready", wr_ready[0], 0);
        repeat (5) step();
        vs = 1'b1;
        step();
        check_val("bt709_a01", act[0][1], 732);
        step();
        wr_valid = 1'b0;
        step();
        check_val("no_second_commit", pending[0], 0);

        // Timeout apply on the 16-cycle instance, then an edge apply clears forced
        vs = 1'b0;
        step();
        commit = 1'b1;
        step();
        commit = 1'b0;
        repeat (20) step();
        check_val("tmo_forced", forced[1], 1);
        commit = 1'b1;
        step();
        commit = 1'b0;
        repeat (3) step();
        vs = 1'b1;
        step();
        check_val("edge_clears_forced", forced[1], 0);
        check_val("t1_forced", forced[2], 1);

        // Invalid preset, and preset colliding with a write
        preset_load = 1'b1; preset_sel = 2'd3;
        step();
        check_val("err_pulse", err[0], 1);
        preset_sel = 2'd2; wr_valid = 1'b1; wr_addr = 4'd9; wr_data = 16'sd77;
        #1;
        check_val("preset_blocks_write", wr_ready[0], 0);
        step();
        preset_load = 1'b0;
        step();
        wr_valid = 1'b0; commit = 1'b1; vs = 1'b0;
        step();
        commit = 1'b0; vs = 1'b1;
        step();
        check_val("ident_a11", act[0][4], 1024);
        check_val("held_write_c0", act[0][9], 77);

        // Commit in the same cycle as a vs rise; vs then held high
        vs = 1'b0;
        step();
        commit = 1'b1; vs = 1'b1;
        step();
        commit = 1'b0;
        repeat (10) step();
        check_val("vs_high_pending", pending[0], 1);
        vs = 1'b0;
        step();
        vs = 1'b1;
        step();
        check_val("second_edge_apply", apply[0], 1);

        // Reset mid-PENDING after loading identity
        vs = 1'b0; preset_load = 1'b1; preset_sel = 2'd2;
        step();
        preset_load = 1'b0; commit = 1'b1;
        step();
        commit = 1'b0;
        repeat (4) step();
        #2;
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) model_reset(k);
        #1;
        check_all();
        check_val("rst_mid_a00", act[0][0], 306);
        check_val("rst_mid_pending", pending[0], 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            wr_valid    = 1'($urandom_range(0, 1));
            wr_addr     = 4'($urandom_range(0, 15));
            wr_data     = 16'($urandom);
            preset_load = ($urandom_range(0, 19) == 0);
            preset_sel  = 2'($urandom_range(0, 3));
            commit      = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 9) == 0) vs = ~vs;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
